data_mem_responder: RTL and testbench

Data-memory responder at the far end of the MEM stage of the RV32IM pipeline. It accepts the load and store request fields that the EX/MEM pipeline register delivers: address, store data, read code and write code. It performs the byte, halfword or word access against a byte-addressable array with configurable latency, and returns sign- or zero-extended load data. While an access is in progress it drives BUSYWAIT so the pipeline registers hold their contents.

---
 rtl/data_mem_responder.sv | 242 ++++++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Data-memory responder at the far end of the MEM stage. It takes the
// load/store request fields from the EX/MEM register and performs a byte,
// halfword or word access against a little-endian, byte-addressable array.
// Each access takes LATENCY cycles with BUSYWAIT high, followed by one DONE
// cycle in which READ_DATA is valid and BUSYWAIT is low.
//
// Parameters:
//   ADDR_WIDTH  byte-address bits used; the array holds 2^ADDR_WIDTH bytes,
//               and upper address bits are ignored (addresses wrap)
//   LATENCY     cycles BUSYWAIT stays high per access, legal range 1..15
//
// Ports:
//   CLK         clock, rising edge
//   RESET       synchronous, active-high reset
//   ADDRESS     byte address of the access
//   WRITE_DATA  store data (low bytes used for SB/SH)
//   MEM_READ    {request, funct3}: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   MEM_WRITE   {request, size}:   00 SB, 01 SH, 10 SW
//   READ_DATA   registered, extended load result; held until the next load
//   BUSYWAIT    combinational stall request to the pipeline
//   MISALIGNED  high for the DONE cycle of a misaligned or illegal access
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    input  logic [3:0]  MEM_READ,
    input  logic [2:0]  MEM_WRITE,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        MISALIGNED
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           wdata;
        logic [3:0]            rd_code;
        logic [2:0]            wr_code;
    } mem_req_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    mem_req_t    req_q, req_d;
    logic [31:0] read_data_q, read_data_d;
    logic        misaligned_q, misaligned_d;

    logic [7:0]  mem [DEPTH];

    // ---------------------------------------------------------------------
    // Request capture
    // ---------------------------------------------------------------------
    mem_req_t    in_req;
    mem_req_t    acc_req;
    logic        req_present;

    // Upper address bits are intentionally ignored.
    logic        unused_addr_hi;
    assign unused_addr_hi = ^ADDRESS[31:ADDR_WIDTH];

    always_comb begin
        in_req         = '0;
        in_req.addr    = ADDRESS[ADDR_WIDTH-1:0];
        in_req.wdata   = WRITE_DATA;
        in_req.rd_code = MEM_READ;
        in_req.wr_code = MEM_WRITE;
    end

    assign req_present = MEM_READ[3] | MEM_WRITE[2];

    // With LATENCY=1 the access is performed on the very edge that leaves
    // IDLE, so it must use the live inputs rather than the latched copy.
    assign acc_req = (state_q == IDLE) ? in_req : req_q;

    // ---------------------------------------------------------------------
    // Access decode: byte enables, legality, load extension
    // ---------------------------------------------------------------------
    logic            acc_is_store;
    logic [3:0]      acc_be;
    logic            acc_bad;
    logic [3:0][7:0] rd_bytes;
    logic [31:0]     ld_data;

    // A store request takes priority over a simultaneous load request.
    assign acc_is_store = acc_req.wr_code[2];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rd_bytes[k] = mem[acc_req.addr + ADDR_WIDTH'(k)];
        end
    end

    always_comb begin
        acc_be  = 4'b0000;
        acc_bad = 1'b0;
        ld_data = 32'h0;
        if (acc_is_store) begin
            case (acc_req.wr_code[1:0])
                2'b00: acc_be = 4'b0001;
                2'b01: begin
                    acc_be  = 4'b0011;
                    acc_bad = acc_req.addr[0];
                end
                2'b10: begin
                    acc_be  = 4'b1111;
                    acc_bad = |acc_req.addr[1:0];
                end
                default: acc_bad = 1'b1;
            endcase
        end else begin
            case (acc_req.rd_code[2:0])
                3'b000: ld_data = {{24{rd_bytes[0][7]}}, rd_bytes[0]};
                3'b001: begin
                    ld_data = {{16{rd_bytes[1][7]}}, rd_bytes[1], rd_bytes[0]};
                    acc_bad = acc_req.addr[0];
                end
                3'b010: begin
                    ld_data = rd_bytes;
                    acc_bad = |acc_req.addr[1:0];
                end
                3'b100: ld_data = {24'h0, rd_bytes[0]};
                3'b101: begin
                    ld_data = {16'h0, rd_bytes[1], rd_bytes[0]};
                    acc_bad = acc_req.addr[0];
                end
                default: acc_bad = 1'b1;
            endcase
            // A rejected load returns zero.
            if (acc_bad) begin
                ld_data = 32'h0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // FSM next-state / outputs
    // ---------------------------------------------------------------------
    logic       do_access;
    logic       busywait;
    logic [3:0] byte_we;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        read_data_d  = read_data_q;
        misaligned_d = 1'b0;
        do_access    = 1'b0;
        busywait     = 1'b0;

        case (state_q)
            IDLE: begin
                busywait = req_present;
                if (req_present) begin
                    req_d = in_req;
                    cnt_d = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        do_access = 1'b1;
                        state_d   = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                busywait = 1'b1;
                cnt_d    = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    do_access = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_access) begin
            misaligned_d = acc_bad;
            // Stores leave the previous load result in place.
            if (!acc_is_store) begin
                read_data_d = ld_data;
            end
        end
    end

    // RESET suppresses the array write so an aborted store has no effect.
    assign byte_we = (do_access && !RESET && acc_is_store && !acc_bad) ? acc_be : 4'b0000;

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            req_q        <= '0;
            read_data_q  <= 32'h0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            read_data_q  <= read_data_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge CLK) begin
        for (int k = 0; k < 4; k++) begin
            if (byte_we[k]) begin
                mem[acc_req.addr + ADDR_WIDTH'(k)] <= acc_req.wdata[8*k +: 8];
            end
        end
    end

    assign READ_DATA  = read_data_q;
    assign BUSYWAIT   = busywait && !RESET;
    assign MISALIGNED = misaligned_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Bench for data_mem_responder. dut0 runs LATENCY=4 and is tracked by a
// byte-array reference model; dut1 runs LATENCY=1 for the short-latency and
// address-wrap scenarios.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] addr0 = '0, wd0 = '0, rdata0;
    logic [3:0]  rd0 = '0;
    logic [2:0]  wr0 = '0;
    logic        bw0, mis0;

    logic        RST1 = 1'b1;
    logic [31:0] addr1 = '0, wd1 = '0, rdata1;
    logic [3:0]  rd1 = '0;
    logic [2:0]  wr1 = '0;
    logic        bw1, mis1;

    int nvec = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(4)) dut0 (
        .CLK(CLK), .RESET(RESET), .ADDRESS(addr0), .WRITE_DATA(wd0),
        .MEM_READ(rd0), .MEM_WRITE(wr0), .READ_DATA(rdata0),
        .BUSYWAIT(bw0), .MISALIGNED(mis0)
    );

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
        .CLK(CLK), .RESET(RST1), .ADDRESS(addr1), .WRITE_DATA(wd1),
        .MEM_READ(rd1), .MEM_WRITE(wr1), .READ_DATA(rdata1),
        .BUSYWAIT(bw1), .MISALIGNED(mis1)
    );

    // ---------------------------------------------------------------------
    // Reference model of dut0: a plain byte array plus the last load result
    // ---------------------------------------------------------------------
    logic [7:0]  mem_m [1024];
    logic [31:0] model_rd = '0;

    task automatic model_access(input logic [3:0] rd, input logic [2:0] wr,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] exp_rd, output bit exp_mis);
        int ad, n;
        logic [31:0] v;
        ad = int'(a % 1024);
        exp_mis = 1'b0;
        if (wr[2]) begin
            n = (wr[1:0] == 2'd0) ? 1 : (wr[1:0] == 2'd1) ? 2 : (wr[1:0] == 2'd2) ? 4 : 0;
            if (n == 0 || ad % n != 0) exp_mis = 1'b1;
            else for (int k = 0; k < n; k++) mem_m[(ad + k) % 1024] = 8'(wd >> (8 * k));
        end else begin
            case (rd[2:0])
                3'd0, 3'd4: n = 1;
                3'd1, 3'd5: n = 2;
                3'd2:       n = 4;
                default:    n = 0;
            endcase
            if (n == 0 || ad % n != 0) begin
                exp_mis  = 1'b1;
                model_rd = '0;
            end else begin
                v = '0;
                for (int k = 0; k < n; k++) v = v | (32'(mem_m[(ad + k) % 1024]) << (8 * k));
                if (!rd[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
                model_rd = v;
            end
        end
        exp_rd = model_rd;
    endtask

    // ---------------------------------------------------------------------
    // Drive one request on dut u and observe the handshake until DONE.
    // Inputs are applied just after a rising edge, outputs sampled on the
    // falling edge. A missing DONE within 40 cycles leaves busy at 40.
    // ---------------------------------------------------------------------
    task automatic run_req(input int u, input logic [3:0] rd, input logic [2:0] wr,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int busy, output logic [31:0] rdata,
                           output int mis_busy, output bit mis_done,
                           output logic [31:0] exp_rd, output bit exp_mis);
        bit done;
        logic b, m;
        @(posedge CLK); #1;
        if (u == 0) begin rd0 = rd; wr0 = wr; addr0 = a; wd0 = wd; end
        else        begin rd1 = rd; wr1 = wr; addr1 = a; wd1 = wd; end
        busy = 0; mis_busy = 0; mis_done = 1'b0; rdata = '0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge CLK);
            b = (u == 0) ? bw0 : bw1;
            m = (u == 0) ? mis0 : mis1;
            if (b) begin
                busy++;
                if (m) mis_busy++;
            end else begin
                done = 1'b1;
                rdata = (u == 0) ? rdata0 : rdata1;
                mis_done = m;
            end
        end
        if (u == 0) begin rd0 = '0; wr0 = '0; end
        else        begin rd1 = '0; wr1 = '0; end
        if (u == 0) model_access(rd, wr, a, wd, exp_rd, exp_mis);
        else begin exp_rd = '0; exp_mis = 1'b0; end
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        RESET = 1'b1; RST1 = 1'b1;
        rd0 = 4'b1010; addr0 = 32'h10;   // request present while in reset
        @(negedge CLK); @(negedge CLK);
        nvec++; if (bw0 !== 1'b0) begin nerr++; $display("FAIL rst_busywait: got %b want 0", bw0); end
        nvec++; if (rdata0 !== 32'h0) begin nerr++; $display("FAIL rst_read_data: got %h want 0", rdata0); end
        nvec++; if (mis0 !== 1'b0) begin nerr++; $display("FAIL rst_misaligned: got %b want 0", mis0); end
        nvec++; if (bw1 !== 1'b0 || rdata1 !== 32'h0) begin nerr++; $display("FAIL rst_dut1: bw %b rd %h want 0/0", bw1, rdata1); end
        rd0 = '0;
        @(posedge CLK); #1; RESET = 1'b0; RST1 = 1'b0;
        @(negedge CLK); @(negedge CLK);
        nvec++; if (bw0 !== 1'b0) begin nerr++; $display("FAIL idle_busywait: got %b want 0", bw0); end
        model_rd = '0;
    endtask

    task automatic test_init();
        int busy, mb; logic [31:0] r, er; bit md, em;
        int bad = 0;
        for (int i = 0; i < 64; i++) begin
            run_req(0, 4'b0000, 3'b110, 32'(i * 4),
                    {8'(i), 8'hA5, 8'(~i), 8'h3C}, busy, r, mb, md, er, em);
            if (busy != 4 || md) bad++;
        end
        nvec++; if (bad != 0) begin nerr++; $display("FAIL init_stores: %0d bad handshakes want 0", bad); end
    endtask

    task automatic test_basic();
        int busy, mb; logic [31:0] r, er, prev; bit md, em;
        prev = rdata0;
        run_req(0, 4'b0000, 3'b110, 32'h10, 32'hDEADBEEF, busy, r, mb, md, er, em);
        nvec++; if (busy !== 4) begin nerr++; $display("FAIL sw_busy_cycles: got %0d want 4", busy); end
        nvec++; if (r !== prev) begin nerr++; $display("FAIL sw_read_hold: got %h want %h", r, prev); end
        run_req(0, 4'b1010, 3'b000, 32'h10, 32'h0, busy, r, mb, md, er, em);
        nvec++; if (busy !== 4) begin nerr++; $display("FAIL lw_busy_cycles: got %0d want 4", busy); end
        nvec++; if (r !== 32'hDEADBEEF) begin nerr++; $display("FAIL lw_data: got %h want deadbeef", r); end
    endtask

    task automatic test_extend();
        int busy, mb; logic [31:0] r, er; bit md, em;
        logic [3:0]  codes [4] = '{4'b1000, 4'b1100, 4'b1001, 4'b1101};
        logic [31:0] addrs [4] = '{32'h13, 32'h13, 32'h12, 32'h12};
        logic [31:0] want  [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD};
        for (int i = 0; i < 4; i++) begin
            run_req(0, codes[i], 3'b000, addrs[i], 32'h0, busy, r, mb, md, er, em);
            nvec++; if (r !== want[i]) begin nerr++; $display("FAIL extend_%0d: got %h want %h", i, r, want[i]); end
        end
    endtask

    task automatic test_subword();
        int busy, mb; logic [31:0] r, er; bit md, em;
        run_req(0, 4'b0000, 3'b100, 32'h11, 32'hFFFFFF55, busy, r, mb, md, er, em);
        run_req(0, 4'b1010, 3'b000, 32'h10, 32'h0, busy, r, mb, md, er, em);
        nvec++; if (r !== 32'hDEAD55EF) begin nerr++; $display("FAIL sb_merge: got %h want dead55ef", r); end
        run_req(0, 4'b0000, 3'b101, 32'h12, 32'hFFFF1234, busy, r, mb, md, er, em);
        run_req(0, 4'b1010, 3'b000, 32'h10, 32'h0, busy, r, mb, md, er, em);
        nvec++; if (r !== 32'h123455EF) begin nerr++; $display("FAIL sh_merge: got %h want 123455ef", r); end
    endtask

    task automatic test_misaligned();
        int busy, mb; logic [31:0] r, er; bit md, em;
        run_req(0, 4'b1010, 3'b000, 32'h12, 32'h0, busy, r, mb, md, er, em);
        nvec++; if (r !== 32'h0) begin nerr++; $display("FAIL mis_lw_data: got %h want 0", r); end
        nvec++; if (md !== 1'b1 || mb !== 0) begin nerr++; $display("FAIL mis_lw_flag: done %b busy-cycles %0d want 1/0", md, mb); end
        nvec++; if (busy !== 4) begin nerr++; $display("FAIL mis_lw_busy: got %0d want 4", busy); end
        run_req(0, 4'b0000, 3'b101, 32'h13, 32'h0000FFFF, busy, r, mb, md, er, em);
        nvec++; if (md !== 1'b1) begin nerr++; $display("FAIL mis_sh_flag: got %b want 1", md); end
        @(negedge CLK);
        nvec++; if (mis0 !== 1'b0) begin nerr++; $display("FAIL mis_one_cycle: got %b want 0", mis0); end
        run_req(0, 4'b1010, 3'b000, 32'h10, 32'h0, busy, r, mb, md, er, em);
        nvec++; if (r !== 32'h123455EF || md !== 1'b0) begin nerr++; $display("FAIL mis_no_write: got %h/%b want 123455ef/0", r, md); end
    endtask

    task automatic test_priority();
        int busy, mb; logic [31:0] r, er, prev; bit md, em;
        prev = rdata0;
        run_req(0, 4'b1010, 3'b110, 32'h30, 32'h13579BDF, busy, r, mb, md, er, em);
        nvec++; if (r !== prev) begin nerr++; $display("FAIL prio_read_hold: got %h want %h", r, prev); end
        run_req(0, 4'b1010, 3'b000, 32'h30, 32'h0, busy, r, mb, md, er, em);
        nvec++; if (r !== 32'h13579BDF) begin nerr++; $display("FAIL prio_write_done: got %h want 13579bdf", r); end
    endtask

    task automatic test_reset_abort();
        int busy, mb; logic [31:0] r, er; bit md, em;
        run_req(0, 4'b1010, 3'b000, 32'h20, 32'h0, busy, r, mb, md, er, em);
        nvec++; if (r !== 32'h08A5F73C) begin nerr++; $display("FAIL abort_pre_load: got %h want 08a5f73c", r); end
        @(posedge CLK); #1; wr0 = 3'b110; addr0 = 32'h20; wd0 = 32'hCAFEF00D;
        @(negedge CLK);                      // IDLE with request
        @(posedge CLK); #1;                  // first BUSY cycle
        @(posedge CLK); #1;                  // second BUSY cycle
        RESET = 1'b1; wr0 = '0;
        @(negedge CLK);
        nvec++; if (bw0 !== 1'b0) begin nerr++; $display("FAIL abort_busywait: got %b want 0", bw0); end
        @(posedge CLK); #1; RESET = 1'b0;
        @(negedge CLK);
        nvec++; if (rdata0 !== 32'h0 || bw0 !== 1'b0 || mis0 !== 1'b0) begin
            nerr++; $display("FAIL abort_state: rd %h bw %b mis %b want 0/0/0", rdata0, bw0, mis0); end
        model_rd = '0;
        run_req(0, 4'b1010, 3'b000, 32'h20, 32'h0, busy, r, mb, md, er, em);
        nvec++; if (r !== 32'h08A5F73C || busy !== 4) begin nerr++; $display("FAIL abort_no_write: got %h/%0d want 08a5f73c/4", r, busy); end
    endtask

    task automatic test_wrap_lat1();
        int busy, mb; logic [31:0] r, er; bit md, em;
        run_req(1, 4'b0000, 3'b110, 32'h400, 32'hAAAAAAAA, busy, r, mb, md, er, em);
        nvec++; if (busy !== 1) begin nerr++; $display("FAIL lat1_sw_busy: got %0d want 1", busy); end
        run_req(1, 4'b1010, 3'b000, 32'h000, 32'h0, busy, r, mb, md, er, em);
        nvec++; if (busy !== 1) begin nerr++; $display("FAIL lat1_lw_busy: got %0d want 1", busy); end
        nvec++; if (r !== 32'hAAAAAAAA) begin nerr++; $display("FAIL lat1_wrap_data: got %h want aaaaaaaa", r); end
        run_req(1, 4'b1001, 3'b000, 32'h401, 32'h0, busy, r, mb, md, er, em);
        nvec++; if (r !== 32'h0 || md !== 1'b1 || busy !== 1) begin
            nerr++; $display("FAIL lat1_mis: got %h/%b/%0d want 0/1/1", r, md, busy); end
    endtask

    // Random back-to-back traffic on dut0 against the model.
    task automatic test_back_to_back();
        int busy, mb; logic [31:0] r, er, a, x; bit md, em;
        logic [3:0] rd; logic [2:0] wr;
        for (int i = 0; i < 80; i++) begin
            x = $urandom;
            a = {x[31:10], 2'b00, x[7:0]};
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            rd = {1'b1, 3'($urandom_range(0, 7))};
            wr = {1'b1, 2'($urandom_range(0, 3))};
            case ($urandom_range(0, 3))
                0, 1: wr[2] = 1'b0;
                2:    rd[3] = 1'b0;
                default: ;
            endcase
            run_req(0, rd, wr, a, $urandom, busy, r, mb, md, er, em);
            nvec++; if (busy !== 4 || mb !== 0) begin nerr++; $display("FAIL b2b_handshake_%0d: busy %0d mis-in-busy %0d want 4/0", i, busy, mb); end
            nvec++; if (r !== er) begin nerr++; $display("FAIL b2b_data_%0d: rd %h wr %h a %h got %h want %h", i, rd, wr, a, r, er); end
            nvec++; if (md !== em) begin nerr++; $display("FAIL b2b_flag_%0d: got %b want %b", i, md, em); end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_basic();
        test_extend();
        test_subword();
        test_misaligned();
        test_priority();
        test_reset_abort();
        test_wrap_lat1();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
